// File: rtl/cdb_rr_sched.sv
// Round-robin scheduler that grants one functional unit per cycle onto the common data bus,
// registers the winning result as the broadcast and counts valid broadcasts.
package cdb_rr_sched_pkg;

    typedef struct packed {
        logic [5:0]  tag;
        logic [31:0] value;
    } fu_cdb_data_t;

    typedef struct packed {
        logic         valid;
        fu_cdb_data_t data;
    } cdb_t;

endpackage

module cdb_rr_sched
    import cdb_rr_sched_pkg::*;
#(
    parameter int unsigned NUM_FU = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [NUM_FU-1:0] fu_done,
    input  fu_cdb_data_t      fu_output_data [NUM_FU],
    output logic [NUM_FU-1:0] ack,
    output cdb_t              cdb,
    output logic [31:0]       bcast_count
);

    localparam int unsigned PtrW = $clog2(NUM_FU);

    logic [PtrW-1:0]   r_rr_ptr;
    cdb_t              r_cdb;
    logic [31:0]       r_bcast_count;

    logic              w_active;
    logic              w_grant;
    logic [PtrW-1:0]   w_grant_idx;
    logic [PtrW:0]     w_sum;
    logic [PtrW-1:0]   w_ptr_next;
    logic [NUM_FU-1:0] w_ack;
    fu_cdb_data_t      w_sel_data;

    assign w_active = !rst && !flush;

    // Scan from the pointer upward with wrap; first requester wins.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (PtrW + 1)'(k);
            if (w_sum >= (PtrW + 1)'(NUM_FU)) begin
                w_sum = w_sum - (PtrW + 1)'(NUM_FU);
            end
            if (w_active && !w_grant && fu_done[w_sum[PtrW-1:0]]) begin
                w_grant     = 1'b1;
                w_grant_idx = w_sum[PtrW-1:0];
            end
        end
    end

    always_comb begin
        w_ack = '0;
        if (w_grant) begin
            w_ack[w_grant_idx] = 1'b1;
        end
    end

    assign w_ptr_next = (w_grant_idx == PtrW'(NUM_FU - 1)) ? '0 : w_grant_idx + PtrW'(1);

    // Only the granted FU's payload is selected, so other lanes never reach the bus.
    assign w_sel_data = fu_output_data[w_grant_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_cdb         <= '0;
            r_bcast_count <= '0;
        end else begin
            r_cdb.valid <= w_grant;
            if (w_grant) begin
                r_cdb.data    <= w_sel_data;
                r_rr_ptr      <= w_ptr_next;
                r_bcast_count <= r_bcast_count + 32'd1;
            end
        end
    end

    assign ack         = w_ack;
    assign cdb         = r_cdb;
    assign bcast_count = r_bcast_count;

endmodule

// File: tb/tb_cdb_rr_sched.sv
// Directed bench for cdb_rr_sched (NUM_FU=4): reset, fairness, idle, wrap, flush,
// counter wrap and mid-operation reset, plus a request/ack protocol monitor.
module tb_cdb_rr_sched;
    import cdb_rr_sched_pkg::*;

    localparam int NUM_FU = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [3:0]   fu_done;
    fu_cdb_data_t fu_output_data [NUM_FU];
    logic [3:0]   ack;
    cdb_t         cdb;
    logic [31:0]  bcast_count;

    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned seq_cnt [NUM_FU];
    logic [3:0]  prev_done = '0;
    logic [3:0]  prev_ack = '0;

    cdb_rr_sched #(.NUM_FU(NUM_FU)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .fu_done        (fu_done),
        .fu_output_data (fu_output_data),
        .ack            (ack),
        .cdb            (cdb),
        .bcast_count    (bcast_count)
    );

    always #5 clk = ~clk;

    // An FU must not withdraw a request that was never acknowledged.
    always @(posedge clk) begin
        if (!rst && !flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                assert (!(prev_done[i] && !prev_ack[i] && !fu_done[i])) else begin
                    n_err++;
                    $error("FAIL protocol_drop fu=%0d observed=dropped expected=held", i);
                end
            end
        end
        prev_done <= fu_done;
        prev_ack  <= ack;
    end

    function automatic fu_cdb_data_t pay(int i, int unsigned n);
        fu_cdb_data_t p;
        p.tag   = 6'(i * 16 + int'(n));
        p.value = 32'hC0DE_0000 + 32'(i * 4096) + 32'(n);
        return p;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic [3:0] done);
        fu_done = done;
        for (int i = 0; i < NUM_FU; i++) fu_output_data[i] = pay(i, seq_cnt[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present requests, check the combinational ack, clock, then check the broadcast.
    task automatic grant_step(string tag, logic [3:0] done, logic [3:0] exp_ack,
                              logic [31:0] exp_cnt);
        int g;
        fu_cdb_data_t exp_data;
        g = -1;
        drive(done);
        #1;
        chk({tag, "_ack"}, 64'(ack), 64'(exp_ack));
        for (int i = 0; i < NUM_FU; i++) if (exp_ack[i]) g = i;
        if (g >= 0) exp_data = pay(g, seq_cnt[g]);
        tick();
        chk({tag, "_valid"}, 64'(cdb.valid), 64'(g >= 0));
        if (g >= 0) begin
            chk({tag, "_data"}, 64'(cdb.data), 64'(exp_data));
            seq_cnt[g]++;
        end
        chk({tag, "_count"}, 64'(bcast_count), 64'(exp_cnt));
    endtask

    initial begin
        fu_cdb_data_t held;
        for (int i = 0; i < NUM_FU; i++) seq_cnt[i] = 0;
        rst   = 1'b1;
        flush = 1'b0;
        drive(4'b1111);
        #1;
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_valid", 64'(cdb.valid), 64'h0);
        chk("rst_data", 64'(cdb.data), 64'h0);
        chk("rst_count", 64'(bcast_count), 64'h0);
        tick();
        chk("rst_hold_ack", 64'(ack), 64'h0);
        chk("rst_hold_valid", 64'(cdb.valid), 64'h0);
        rst = 1'b0;

        // Fairness: every FU requesting; grants rotate starting at FU0.
        for (int c = 0; c < 8; c++) begin
            grant_step($sformatf("fair%0d", c), 4'b1111, 4'(1 << (c % 4)), 32'(c + 1));
        end
        chk("fair_ptr", 64'(dut.r_rr_ptr), 64'h0);

        // Drain the outstanding requests, each FU dropping after its ack.
        grant_step("drain0", 4'b0111, 4'b0001, 32'd9);
        grant_step("drain1", 4'b0110, 4'b0010, 32'd10);
        grant_step("drain2", 4'b0100, 4'b0100, 32'd11);
        held = pay(2, seq_cnt[2] - 1);

        // Idle then a single request from FU2.
        for (int c = 0; c < 5; c++) begin
            grant_step($sformatf("idle%0d", c), 4'b0000, 4'b0000, 32'd11);
            chk($sformatf("idle%0d_hold", c), 64'(cdb.data), 64'(held));
        end
        grant_step("single", 4'b0100, 4'b0100, 32'd12);
        chk("single_ptr", 64'(dut.r_rr_ptr), 64'd3);

        // Pointer at 3: search wraps to FU0, then FU1.
        grant_step("wrap0", 4'b0011, 4'b0001, 32'd13);
        grant_step("wrap1", 4'b0010, 4'b0010, 32'd14);
        chk("wrap_ptr", 64'(dut.r_rr_ptr), 64'd2);

        // Flush suppresses FU2's grant; it wins once flush drops.
        flush = 1'b1;
        grant_step("flush", 4'b0100, 4'b0000, 32'd14);
        chk("flush_ptr", 64'(dut.r_rr_ptr), 64'd2);
        flush = 1'b0;
        grant_step("post_flush", 4'b0100, 4'b0100, 32'd15);
        chk("post_flush_ptr", 64'(dut.r_rr_ptr), 64'd3);

        // Counter wrap via a preloaded count.
        drive(4'b0000);
        force dut.r_bcast_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_bcast_count;
        #1;
        chk("preload_count", 64'(bcast_count), 64'hFFFF_FFFE);
        grant_step("cnt_max", 4'b0001, 4'b0001, 32'hFFFF_FFFF);
        grant_step("cnt_wrap", 4'b0001, 4'b0001, 32'h0);

        // Reset asserted mid-operation discards the in-flight broadcast.
        grant_step("pre_rst", 4'b1111, 4'b0010, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(cdb.valid), 64'h0);
        chk("midrst_data", 64'(cdb.data), 64'h0);
        chk("midrst_count", 64'(bcast_count), 64'h0);
        chk("midrst_ack", 64'(ack), 64'h0);
        chk("midrst_ptr", 64'(dut.r_rr_ptr), 64'h0);
        tick();
        chk("midrst_hold_valid", 64'(cdb.valid), 64'h0);
        rst = 1'b0;
        grant_step("after_rst", 4'b1111, 4'b0001, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
